// File: rtl/queue_reader.sv
// Queue reader: pops a burst of len_i bytes from a queue into a 2-entry skid
// buffer and presents them on a valid/ready byte stream.
// Latency: a pop at an edge shows on m_valid_o/m_data_o in the next cycle.
// Backpressure: m_ready_i=0 fills the buffer, then pops stop until space frees.
// Ports:
//   Clk_i, Rst_i (async active-low)    - clock and reset
//   q_empty_i, q_data_i, q_en_o, q_rw_o - queue read side (q_rw_o fixed 0)
//   start_i, len_i, abort_i            - burst control
//   m_valid_o, m_data_o, m_ready_i     - output byte stream
//   busy_o, done_o, remaining_o        - status
module queue_reader (
  input  logic        Clk_i,
  input  logic        Rst_i,
  input  logic        q_empty_i,
  input  logic [7:0]  q_data_i,
  output logic        q_en_o,
  output logic        q_rw_o,
  input  logic        start_i,
  input  logic [10:0] len_i,
  input  logic        abort_i,
  output logic        m_valid_o,
  output logic [7:0]  m_data_o,
  input  logic        m_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [10:0] remaining_o
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [1:0]  occ, occ_nxt;
  logic [10:0] remaining, remaining_nxt;
  logic [7:0]  buf0, buf0_nxt;   // oldest entry
  logic [7:0]  buf1, buf1_nxt;
  logic        done, done_nxt;
  logic        xfer;
  logic        pop;

  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      state     <= IDLE;
      occ       <= 2'd0;
      remaining <= 11'd0;
      buf0      <= 8'd0;
      buf1      <= 8'd0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      occ       <= occ_nxt;
      remaining <= remaining_nxt;
      buf0      <= buf0_nxt;
      buf1      <= buf1_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    xfer = (occ != 2'd0) && m_ready_i;
    // A full buffer may still accept a pop when a byte leaves on the same edge.
    pop  = (state == RUN) && !abort_i && !q_empty_i && (remaining != 11'd0) &&
           ((occ < 2'd2) || xfer);
  end

  always_comb begin
    state_nxt     = state;
    occ_nxt       = occ;
    remaining_nxt = remaining;
    buf0_nxt      = buf0;
    buf1_nxt      = buf1;
    done_nxt      = 1'b0;

    if (abort_i && (state != IDLE)) begin
      // Abort wins over everything: drop buffered bytes, no done pulse.
      state_nxt     = IDLE;
      occ_nxt       = 2'd0;
      remaining_nxt = 11'd0;
    end else begin
      case ({pop, xfer})
        2'b01: begin
          buf0_nxt = buf1;
          occ_nxt  = occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) buf0_nxt = q_data_i;
          else             buf1_nxt = q_data_i;
          occ_nxt = occ + 2'd1;
        end
        2'b11: begin
          // Simultaneous in/out: shift and append so order is kept.
          if (occ == 2'd1) begin
            buf0_nxt = q_data_i;
          end else begin
            buf0_nxt = buf1;
            buf1_nxt = q_data_i;
          end
        end
        default: ;
      endcase

      if (pop) remaining_nxt = remaining - 11'd1;

      case (state)
        IDLE: begin
          if (start_i) begin
            remaining_nxt = len_i;
            if (len_i != 11'd0) state_nxt = RUN;
            else                done_nxt  = 1'b1;
          end
        end
        RUN: begin
          if (pop && (remaining == 11'd1)) state_nxt = FLUSH;
        end
        FLUSH: begin
          if (occ_nxt == 2'd0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign q_en_o      = pop;
  assign q_rw_o      = 1'b0;
  assign m_valid_o   = (occ != 2'd0);
  assign m_data_o    = (occ != 2'd0) ? buf0 : 8'd0;
  assign busy_o      = (state != IDLE);
  assign done_o      = done;
  assign remaining_o = remaining;

endmodule

// File: tb/tb_queue_reader.sv
// Bench for queue_reader: a queue model drives the queue side, a byte-list
// model of the burst predicts every output each cycle, and directed bursts
// pin the model with literal expectations.
module tb_queue_reader;

  logic        Clk_i = 1'b0;
  logic        Rst_i = 1'b0;
  logic        q_empty_i = 1'b1;
  logic [7:0]  q_data_i = 8'd0;
  logic        q_en_o;
  logic        q_rw_o;
  logic        start_i = 1'b0;
  logic [10:0] len_i = 11'd0;
  logic        abort_i = 1'b0;
  logic        m_valid_o;
  logic [7:0]  m_data_o;
  logic        m_ready_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [10:0] remaining_o;

  queue_reader dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .q_empty_i(q_empty_i), .q_data_i(q_data_i),
    .q_en_o(q_en_o), .q_rw_o(q_rw_o), .start_i(start_i), .len_i(len_i),
    .abort_i(abort_i), .m_valid_o(m_valid_o), .m_data_o(m_data_o),
    .m_ready_i(m_ready_i), .busy_o(busy_o), .done_o(done_o),
    .remaining_o(remaining_o)
  );

  always #5 Clk_i = ~Clk_i;

  int errors = 0;
  int checks = 0;

  // Environment queue and reference model state.
  byte unsigned fifo[$];
  byte unsigned mbuf[$];     // bytes held for output, oldest first
  byte unsigned obs[$];      // bytes seen transferred on the output
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2;
  int mode = M_IDLE;
  int mrem = 0;
  bit mdone = 1'b0;
  int done_cnt, qen_cnt, busy_cnt, pop_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_stats();
    obs.delete();
    done_cnt = 0; qen_cnt = 0; busy_cnt = 0; pop_cnt = 0;
  endtask

  // One clock cycle: drive at negedge, compare against the model, then
  // advance the model and the environment queue at the rising edge.
  task automatic step(input bit st, input int ln, input bit ab, input bit rdy, input bit fe);
    bit xfer_e, qen_e, dut_qen;
    int old;
    byte unsigned front;
    @(negedge Clk_i);
    start_i   = st;
    len_i     = ln[10:0];
    abort_i   = ab;
    m_ready_i = rdy;
    q_empty_i = fe || (fifo.size() == 0);
    front     = (fifo.size() != 0) ? fifo[0] : 8'd0;
    q_data_i  = front;
    #1;
    xfer_e = (mbuf.size() != 0) && rdy;
    qen_e  = (mode == M_RUN) && !ab && !q_empty_i && (mrem != 0) &&
             ((mbuf.size() < 2) || xfer_e);
    chk("q_en", q_en_o, qen_e);
    chk("q_rw", q_rw_o, 0);
    chk("m_valid", m_valid_o, mbuf.size() != 0);
    chk("m_data", m_data_o, (mbuf.size() != 0) ? mbuf[0] : 8'd0);
    chk("busy", busy_o, mode != M_IDLE);
    chk("done", done_o, mdone);
    chk("remaining", remaining_o, mrem);
    if (done_o) done_cnt++;
    if (q_en_o) qen_cnt++;
    if (busy_o) busy_cnt++;
    if (m_valid_o && m_ready_i) obs.push_back(m_data_o);
    dut_qen = q_en_o;
    @(posedge Clk_i);
    if (ab && (mode != M_IDLE)) begin
      mode = M_IDLE; mbuf.delete(); mrem = 0; mdone = 1'b0;
    end else begin
      old = mode;
      mdone = 1'b0;
      if (xfer_e) void'(mbuf.pop_front());
      if (qen_e) begin
        mbuf.push_back(front);
        mrem--;
        if (mrem == 0) mode = M_FLUSH;
      end
      if (old == M_IDLE && st) begin
        mrem = ln;
        if (ln != 0) mode = M_RUN;
        else         mdone = 1'b1;
      end else if (old == M_FLUSH && mbuf.size() == 0) begin
        mode = M_IDLE; mdone = 1'b1;
      end
    end
    if (dut_qen && fifo.size() != 0) begin
      void'(fifo.pop_front());
      pop_cnt++;
    end
  endtask

  // Reset pulled low between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    @(posedge Clk_i);
    #2 Rst_i = 1'b0;
    #1;
    chk({tag, "_q_en"}, q_en_o, 0);
    chk({tag, "_q_rw"}, q_rw_o, 0);
    chk({tag, "_m_valid"}, m_valid_o, 0);
    chk({tag, "_m_data"}, m_data_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_remaining"}, remaining_o, 0);
    mode = M_IDLE; mbuf.delete(); mrem = 0; mdone = 1'b0;
    @(posedge Clk_i);
    #2 Rst_i = 1'b1;
  endtask

  initial begin
    int rdy_pct;
    async_reset("reset");

    // Three-byte burst with a free-running sink.
    fifo = '{8'h11, 8'h22, 8'h33};
    clr_stats();
    step(1, 3, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
    chk("b3_count", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("b3_byte0", obs[0], 8'h11);
      chk("b3_byte1", obs[1], 8'h22);
      chk("b3_byte2", obs[2], 8'h33);
    end
    chk("b3_done_cnt", done_cnt, 1);
    chk("b3_pops", pop_cnt, 3);
    chk("b3_busy_end", busy_o, 0);

    // Sink stalled: exactly two pops, then the buffer holds.
    fifo = '{8'h41, 8'h42, 8'h43, 8'h44};
    clr_stats();
    step(1, 4, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    #2;
    chk("bp_pops", pop_cnt, 2);
    chk("bp_q_en", q_en_o, 0);
    chk("bp_remaining", remaining_o, 2);
    chk("bp_head", m_data_o, 8'h41);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    chk("bp_count", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("bp_byte0", obs[0], 8'h41);
      chk("bp_byte3", obs[3], 8'h44);
    end
    chk("bp_done_cnt", done_cnt, 1);

    // Queue empty for five cycles, then two bytes arrive.
    fifo.delete();
    clr_stats();
    step(1, 2, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    chk("empty_no_pop", qen_cnt, 0);
    fifo = '{8'hA5, 8'h5A};
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    chk("empty_count", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("empty_byte0", obs[0], 8'hA5);
      chk("empty_byte1", obs[1], 8'h5A);
    end
    chk("empty_done_cnt", done_cnt, 1);

    // Zero-length burst.
    fifo = '{8'h77};
    clr_stats();
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_q_en_cnt", qen_cnt, 0);
    chk("zero_busy_cnt", busy_cnt, 0);

    // Abort after four pops of a ten-byte burst.
    fifo.delete();
    for (int i = 1; i <= 10; i++) fifo.push_back(byte'(i));
    clr_stats();
    step(1, 10, 0, 1, 0);
    for (int i = 0; i < 30 && pop_cnt < 4; i++) step(0, 0, 0, 1, 0);
    chk("abort_pops", pop_cnt, 4);
    step(0, 0, 1, 1, 0);
    #2;
    chk("abort_busy", busy_o, 0);
    chk("abort_valid", m_valid_o, 0);
    chk("abort_remaining", remaining_o, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    chk("abort_fifo_left", fifo.size(), 6);
    chk("abort_no_done", done_cnt, 0);

    // Reset mid-burst, then a fresh burst right after release.
    fifo.delete();
    for (int i = 0; i < 8; i++) fifo.push_back(byte'(8'hC0 + i));
    step(1, 8, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    async_reset("midrst");
    fifo = '{8'hD1, 8'hD2, 8'hD3};
    clr_stats();
    step(1, 3, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
    chk("post_rst_count", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("post_rst_byte0", obs[0], 8'hD1);
      chk("post_rst_byte2", obs[2], 8'hD3);
    end
    chk("post_rst_done_cnt", done_cnt, 1);

    // Randomized traffic: stalls, backpressure, stray starts and aborts.
    fifo.delete();
    rdy_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      bit st, ab, rdy, fe;
      int ln;
      if (c % 500 == 0) rdy_pct = $urandom_range(20, 100);
      st  = ($urandom % 6) == 0;
      ln  = (($urandom % 10) == 0) ? $urandom_range(0, 90) : $urandom_range(0, 12);
      ab  = ($urandom % 70) == 0;
      rdy = $urandom_range(1, 100) <= rdy_pct;
      fe  = ($urandom % 5) == 0;
      if (fifo.size() < 24 && ($urandom % 2) == 0) fifo.push_back(byte'($urandom));
      step(st, ln, ab, rdy, fe);
    end
    for (int c = 0; c < 400 && mode != M_IDLE; c++) begin
      if (fifo.size() < 4) fifo.push_back(byte'($urandom));
      step(0, 0, 0, 1, 0);
    end
    step(0, 0, 0, 1, 0);
    chk("drain_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/queue_reader.md
QUEUE_READER -- requirements
Module: queue_reader

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: Clk_i and Rst_i.
REQ-002 Clk_i  input  1  rising-edge clock for all state.
REQ-003 Rst_i  input  1  asynchronous active-low reset (0 = reset).
REQ-004 q_empty_i  input  1  queue empty flag.
REQ-005 q_data_i  input  8  queue read data; combinational from the current front entry.
REQ-006 q_en_o  output  1  queue enable; a pop occurs at the rising edge when 1.
REQ-007 q_rw_o  output  1  queue direction; SHALL be constant 0 (read).
REQ-008 start_i  input  1  one-cycle request to begin a burst.
REQ-009 len_i  input  11  burst length in bytes (0..2047), sampled with start_i.
REQ-010 abort_i  input  1  cancels an active burst.
REQ-011 m_valid_o  output  1  output byte valid.
REQ-012 m_data_o  output  8  output byte.
REQ-013 m_ready_i  input  1  downstream accepts; a transfer occurs when m_valid_o and m_ready_i are both 1 at an edge.
REQ-014 busy_o  output  1  high while not IDLE.
REQ-015 done_o  output  1  one-cycle pulse at burst completion.
REQ-016 remaining_o  output  11  bytes still to be popped in the current burst.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and FLUSH, with busy_o = (state != IDLE).
REQ-018 IDLE: start_i=1 loads remaining from len_i.
- len_i != 0 -> RUN.
- len_i = 0 -> done_o=1 on the next cycle, state stays IDLE, no pops.
REQ-019 start_i SHALL be ignored outside IDLE.
REQ-020 The block SHALL contain a 2-entry output buffer (occupancy 0..2).
- m_valid_o = (occ != 0).
- m_data_o = oldest entry; 0 when occ = 0.
REQ-021 In RUN, q_en_o SHALL be combinationally 1 iff q_empty_i=0, remaining!=0, and (occ<2 or a transfer occurs this cycle).
REQ-022 On an edge with q_en_o=1, q_data_i SHALL be written into the buffer and remaining SHALL decrement by 1 (pop-to-m_valid_o latency = 1 cycle).
REQ-023 A pop and a transfer on the same edge SHALL leave occ unchanged and preserve byte order.
REQ-024 RUN -> FLUSH on the edge where remaining goes 1 -> 0.
REQ-025 FLUSH: q_en_o=0; on the edge where occ becomes 0, done_o pulses for one cycle and the state returns to IDLE.
REQ-026 q_empty_i=1 in RUN SHALL stall pops without losing state; popping resumes the first cycle q_empty_i=0.
REQ-027 m_data_o SHALL be held stable while m_valid_o=1 and m_ready_i=0.
REQ-028 abort_i=1 in RUN or FLUSH SHALL, at the next edge:
- return to IDLE;
- clear occ and remaining;
- force q_en_o=0 in the abort cycle;
- produce no done_o pulse.
REQ-029 abort_i SHALL have priority over every other event in the same cycle; abort_i in IDLE has no effect.
REQ-030 Order of delivered bytes SHALL equal queue pop order; no byte is duplicated or dropped except on abort.

Reset
REQ-031 Rst_i=0 SHALL immediately and asynchronously force:
- state IDLE, occ=0, remaining=0;
- q_en_o=0, q_rw_o=0, m_valid_o=0, m_data_o=0, busy_o=0, done_o=0.
REQ-032 Reset asserted mid-burst SHALL discard buffered bytes.
REQ-033 After Rst_i deasserts, the first start_i SHALL be honoured at the first rising edge.

Verification
REQ-034 Queue holds 0x11,0x22,0x33; start_i with len_i=3, m_ready_i=1 -> 3 pops on consecutive cycles; m_data_o shows 0x11,0x22,0x33 on consecutive cycles; done_o pulses once; busy_o falls.
REQ-035 len_i=4, m_ready_i=0 throughout -> exactly 2 pops, then q_en_o=0 with occ=2 and remaining_o=2; raising m_ready_i completes all 4 in order.
REQ-036 len_i=2, queue empty for 5 cycles then loaded with 0xA5,0x5A -> no q_en_o while empty; output 0xA5 then 0x5A; done_o pulses.
REQ-037 start_i with len_i=0 -> done_o=1 for exactly one cycle; q_en_o never asserts; busy_o stays 0.
REQ-038 Burst len_i=10; abort_i after 4 pops -> IDLE next cycle, m_valid_o=0, remaining_o=0, no done_o; queue retains the other 6 entries.
REQ-039 Rst_i pulled low mid-burst between clock edges -> all outputs 0 immediately; a new start_i after release runs normally.
